// File: rtl/pico_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pico_ctrl_pkg : opcodes, states and ALU codes for the pico control |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pico_ctrl_pkg;

    localparam int OP_W     = 4;
    localparam int FUNC_W   = 3;
    localparam int DEF_N    = 8;
    localparam int DEF_RA_W = 3;
    localparam int DEF_PC_W = 8;

    // ALU function codes shared with the ALU
    localparam logic [FUNC_W-1:0] ALU_RA   = 3'd0;
    localparam logic [FUNC_W-1:0] ALU_RB   = 3'd1;
    localparam logic [FUNC_W-1:0] ALU_RADD = 3'd2;
    localparam logic [FUNC_W-1:0] ALU_RSUB = 3'd3;
    localparam logic [FUNC_W-1:0] ALU_RAND = 3'd4;
    localparam logic [FUNC_W-1:0] ALU_ROR  = 3'd5;
    localparam logic [FUNC_W-1:0] ALU_RXOR = 3'd6;
    localparam logic [FUNC_W-1:0] ALU_RNOR = 3'd7;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_ADDI = 4'h2, OP_SUB  = 4'h3,
        OP_SUBI = 4'h4, OP_AND  = 4'h5, OP_OR   = 4'h6, OP_XOR  = 4'h7,
        OP_NOR  = 4'h8, OP_MOV  = 4'h9, OP_BEQ  = 4'hA, OP_BNE  = 4'hB,
        OP_J    = 4'hC, OP_IN   = 4'hD, OP_OUT  = 4'hE, OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_WB       = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_WAIT_OUT = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PC_INC = 2'd0,
        PC_REL = 2'd1,
        PC_ABS = 2'd2
    } pc_sel_t;

    function automatic logic [FUNC_W-1:0] alu_func_of(input opcode_t op);
        logic [FUNC_W-1:0] f;
        f = ALU_RA;
        unique case (op)
            OP_ADD, OP_ADDI:                  f = ALU_RADD;
            OP_SUB, OP_SUBI, OP_BEQ, OP_BNE:  f = ALU_RSUB;
            OP_AND:                           f = ALU_RAND;
            OP_OR:                            f = ALU_ROR;
            OP_XOR:                           f = ALU_RXOR;
            OP_NOR:                           f = ALU_RNOR;
            OP_MOV:                           f = ALU_RB;
            default:                          f = ALU_RA;
        endcase
        return f;
    endfunction

    function automatic logic uses_imm(input opcode_t op);
        return (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

    function automatic logic writes_rf(input opcode_t op);
        return ((op >= OP_ADD) && (op <= OP_MOV)) || (op == OP_IN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pico_control_fsm_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pico_control_fsm_pc_unit : PC register with +1/relative/abs update |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pico_control_fsm_pc_unit
    import pico_ctrl_pkg::*;
#(
    parameter int N    = 8,
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            i_load,
    input  pc_sel_t         i_sel,
    input  logic [N-1:0]    i_imm,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_next;
    logic [PC_W-1:0] w_imm_sx;
    logic [PC_W-1:0] w_imm_zx;

    // Sized casts sign/zero-extend or truncate imm to PC width
    assign w_imm_sx = PC_W'($signed(i_imm));
    assign w_imm_zx = PC_W'(i_imm);

    always_comb begin
        w_next = r_pc + PC_W'(1);
        unique case (i_sel)
            PC_REL:  w_next = r_pc + w_imm_sx;
            PC_ABS:  w_next = w_imm_zx;
            default: w_next = r_pc + PC_W'(1);
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= w_next;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/pico_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pico_control_fsm : multi-cycle FETCH/DECODE/EXEC/WB sequencer      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pico_control_fsm
    import pico_ctrl_pkg::*;
#(
    parameter int N    = 8,
    parameter int RA_W = 3,
    parameter int PC_W = 8
) (
    input  logic                    clk,
    input  logic                    n_reset,
    output logic [PC_W-1:0]         pc,
    input  logic [OP_W+2*RA_W+N-1:0] instr,
    output logic [RA_W-1:0]         rd_addr,
    output logic [RA_W-1:0]         rs_addr,
    output logic [N-1:0]            imm,
    output logic                    imm_sel,
    output logic [FUNC_W-1:0]       alu_func,
    input  logic                    alu_zf,
    output logic                    wb_sel,
    output logic                    rf_we,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    halted
);

    localparam int IW     = OP_W + 2*RA_W + N;
    localparam int RS_LSB = N;
    localparam int RD_LSB = N + RA_W;
    localparam int OP_LSB = N + 2*RA_W;

    state_t        r_state;
    state_t        w_next_state;
    logic [IW-1:0] r_ir;
    logic          r_zf;
    opcode_t       w_op;
    pc_sel_t       w_pc_sel;
    logic          w_pc_load;

    assign w_op    = opcode_t'(r_ir[OP_LSB +: OP_W]);
    assign rd_addr = r_ir[RD_LSB +: RA_W];
    assign rs_addr = r_ir[RS_LSB +: RA_W];
    assign imm     = r_ir[N-1:0];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_zf    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH) begin
                r_ir <= instr;
            end
            if (r_state == S_EXEC) begin
                r_zf <= alu_zf;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        alu_func     = ALU_RA;
        imm_sel      = 1'b0;
        wb_sel       = 1'b0;
        rf_we        = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        halted       = 1'b0;
        unique case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                unique case (w_op)
                    OP_IN:   w_next_state = S_WAIT_IN;
                    OP_OUT:  w_next_state = S_WAIT_OUT;
                    OP_HALT: w_next_state = S_HALT;
                    default: w_next_state = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_func     = alu_func_of(w_op);
                imm_sel      = uses_imm(w_op);
                w_next_state = S_WB;
            end
            S_WB: begin
                // ALU operands stay selected so the written result is stable
                alu_func     = alu_func_of(w_op);
                imm_sel      = uses_imm(w_op);
                rf_we        = writes_rf(w_op);
                wb_sel       = (w_op == OP_IN);
                w_next_state = S_FETCH;
            end
            S_WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = S_WB;
                end
            end
            S_WAIT_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_WB;
                end
            end
            S_HALT:  halted = 1'b1;
            default: w_next_state = S_FETCH;
        endcase
    end

    assign w_pc_load = (r_state == S_WB);

    always_comb begin
        w_pc_sel = PC_INC;
        if (w_op == OP_J) begin
            w_pc_sel = PC_ABS;
        end else if ((w_op == OP_BEQ && r_zf) || (w_op == OP_BNE && !r_zf)) begin
            w_pc_sel = PC_REL;
        end
    end

    pico_control_fsm_pc_unit #(
        .N    (N),
        .PC_W (PC_W)
    ) u_pc_unit (
        .clk     (clk),
        .n_reset (n_reset),
        .i_load  (w_pc_load),
        .i_sel   (w_pc_sel),
        .i_imm   (imm),
        .o_pc    (pc)
    );

endmodule
`default_nettype wire

// File: tb/tb_pico_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pico_control_fsm : directed-vector bench for pico_control_fsm   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pico_control_fsm;

    localparam int N    = 8;
    localparam int RA_W = 3;
    localparam int PC_W = 8;
    localparam int IW   = 18;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_J    = 4'hC;
    localparam logic [3:0] OP_IN   = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] F_RA   = 3'd0;
    localparam logic [2:0] F_RADD = 3'd2;
    localparam logic [2:0] F_RSUB = 3'd3;

    logic            clk = 1'b0;
    logic            n_reset;
    logic [PC_W-1:0] pc;
    logic [IW-1:0]   instr;
    logic [RA_W-1:0] rd_addr;
    logic [RA_W-1:0] rs_addr;
    logic [N-1:0]    imm;
    logic            imm_sel;
    logic [2:0]      alu_func;
    logic            alu_zf;
    logic            wb_sel;
    logic            rf_we;
    logic            in_valid;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic            halted;

    logic [IW-1:0]   rom [0:255];
    int              n_checks = 0;
    int              n_fail   = 0;

    always #5 clk = ~clk;

    assign instr = rom[pc];

    pico_control_fsm #(
        .N    (N),
        .RA_W (RA_W),
        .PC_W (PC_W)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .pc        (pc),
        .instr     (instr),
        .rd_addr   (rd_addr),
        .rs_addr   (rs_addr),
        .imm       (imm),
        .imm_sel   (imm_sel),
        .alu_func  (alu_func),
        .alu_zf    (alu_zf),
        .wb_sel    (wb_sel),
        .rf_we     (rf_we),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halted    (halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [7:0] im);
        return {op, rd, rs, im};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = mk(OP_NOP, 3'd0, 3'd0, 8'd0);
    endtask

    // Hold reset for two cycles, release on a falling edge: caller sits in cycle 1 (FETCH)
    task automatic do_reset();
        n_reset = 1'b0;
        step(2);
        n_reset = 1'b1;
    endtask

    initial begin
        n_reset   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_zf    = 1'b0;
        clear_rom();
        rom[0] = mk(OP_ADDI, 3'd1, 3'd0, 8'd5);

        // Reset values
        step(2);
        chk("rst_pc",        pc,        32'h0);
        chk("rst_rf_we",     rf_we,     32'h0);
        chk("rst_imm_sel",   imm_sel,   32'h0);
        chk("rst_wb_sel",    wb_sel,    32'h0);
        chk("rst_in_ready",  in_ready,  32'h0);
        chk("rst_out_valid", out_valid, 32'h0);
        chk("rst_halted",    halted,    32'h0);
        chk("rst_alu_func",  alu_func,  F_RA);
        chk("rst_rd_addr",   rd_addr,   32'h0);
        chk("rst_rs_addr",   rs_addr,   32'h0);
        chk("rst_imm",       imm,       32'h0);
        n_reset = 1'b1;

        // ADDI r1,5 at pc=0
        chk("addi_c1_pc", pc, 32'h0);
        step(1);
        chk("addi_dec_rd",  rd_addr, 32'h1);
        chk("addi_dec_imm", imm,     32'h5);
        chk("addi_dec_we",  rf_we,   32'h0);
        step(1);
        chk("addi_ex_func", alu_func, F_RADD);
        chk("addi_ex_isel", imm_sel,  32'h1);
        chk("addi_ex_we",   rf_we,    32'h0);
        step(1);
        chk("addi_wb_we",   rf_we,    32'h1);
        chk("addi_wb_wbs",  wb_sel,   32'h0);
        chk("addi_wb_pc",   pc,       32'h0);
        step(1);
        chk("addi_c5_pc",   pc,       32'h1);
        chk("addi_c5_we",   rf_we,    32'h0);

        // Asynchronous reset in the middle of EXEC of ADD
        clear_rom();
        rom[0] = mk(OP_ADD, 3'd2, 3'd3, 8'd0);
        do_reset();
        step(2);
        chk("add_ex_func", alu_func, F_RADD);
        chk("add_ex_isel", imm_sel,  32'h0);
        #2 n_reset = 1'b0;
        #1;
        chk("arst_func", alu_func, F_RA);
        chk("arst_we",   rf_we,    32'h0);
        step(1);
        chk("arst_next_we", rf_we, 32'h0);
        chk("arst_next_pc", pc,    32'h0);
        n_reset = 1'b1;
        step(2);
        chk("arst_re_ex_we", rf_we, 32'h0);
        step(1);
        chk("arst_re_wb_we", rf_we, 32'h1);
        step(1);
        chk("arst_re_pc", pc, 32'h1);

        // BEQ at pc=3 with imm=-2, then J to 0xFF and wrap to 0
        clear_rom();
        rom[3] = mk(OP_BEQ, 3'd1, 3'd2, 8'hFE);
        rom[4] = mk(OP_J,   3'd0, 3'd0, 8'hFF);
        alu_zf = 1'b1;
        do_reset();
        step(12);
        chk("beq_at_pc3", pc, 32'h3);
        step(2);
        chk("beq_ex_func", alu_func, F_RSUB);
        step(1);
        chk("beq_wb_we", rf_we, 32'h0);
        step(1);
        chk("beq_taken_pc", pc, 32'h1);
        alu_zf = 1'b0;
        step(8);
        chk("beq_again_pc3", pc, 32'h3);
        step(4);
        chk("beq_not_taken_pc", pc, 32'h4);
        step(4);
        chk("j_pc", pc, 32'hFF);
        step(4);
        chk("wrap_pc", pc, 32'h0);

        // IN with delayed valid, OUT with delayed ready, then HALT
        clear_rom();
        rom[0] = mk(OP_IN,   3'd3, 3'd0, 8'd0);
        rom[1] = mk(OP_OUT,  3'd4, 3'd0, 8'd0);
        rom[2] = mk(OP_HALT, 3'd0, 3'd0, 8'd0);
        do_reset();
        out_ready = 1'b1;
        step(1);
        chk("in_dec_ready", in_ready, 32'h0);
        step(1);
        for (int i = 0; i < 10; i++) begin
            chk("in_wait_ready", in_ready, 32'h1);
            chk("in_wait_we",    rf_we,    32'h0);
            step(1);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        chk("in_xfer_ready", in_ready, 32'h1);
        step(1);
        chk("in_wb_wbsel", wb_sel,   32'h1);
        chk("in_wb_we",    rf_we,    32'h1);
        chk("in_wb_ready", in_ready, 32'h0);
        step(1);
        chk("in_next_pc", pc,    32'h1);
        chk("in_next_we", rf_we, 32'h0);
        step(2);
        chk("out_rd_addr", rd_addr,  32'h4);
        chk("out_func",    alu_func, F_RA);
        for (int i = 0; i < 3; i++) begin
            chk("out_wait_valid", out_valid, 32'h1);
            chk("out_wait_pc",    pc,        32'h1);
            step(1);
        end
        out_ready = 1'b1;
        chk("out_xfer_valid", out_valid, 32'h1);
        step(1);
        chk("out_wb_valid", out_valid, 32'h0);
        chk("out_wb_we",    rf_we,     32'h0);
        out_ready = 1'b0;
        step(1);
        chk("out_next_pc", pc, 32'h2);
        step(1);
        chk("halt_dec_halted", halted, 32'h0);
        step(1);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("halt_halted", halted,   32'h1);
            chk("halt_we",     rf_we,    32'h0);
            chk("halt_ready",  in_ready, 32'h0);
            chk("halt_pc",     pc,       32'h2);
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
